// File: rtl/fft_pkg.sv
// Shared constants for the FFT datapath: sample/twiddle widths and Q1.7 scaling.
package fft_pkg;
    localparam int FFT_DW    = 17;
    localparam int FFT_TW    = 8;
    localparam int FFT_LOG_N = 4;
    localparam int SAT_MAX   = 65535;
    localparam int SAT_MIN   = -65536;
    localparam int FRAC_SH   = 7;
endpackage

// File: rtl/fft_twiddle_stage_twiddle_rom.sv
// Combinational twiddle lookup W_N^k in Q1.7, folded from a 64-point quarter-wave cosine table.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int LOG_N    = FFT_LOG_N,
    parameter int TW       = FFT_TW
) (
    input  logic [LOG_N-1:0]     k_i,
    output logic signed [TW-1:0] w_re_o,
    output logic signed [TW-1:0] w_im_o
);
    localparam int W_MAX = (1 << (TW - 1)) - 1;

    logic [5:0] m;
    logic [4:0] r;
    logic [4:0] rc;
    int         c;
    int         s;

    function automatic int qcos(input logic [4:0] idx);
        case (idx)
            5'd0:    return 128;
            5'd1:    return 127;
            5'd2:    return 126;
            5'd3:    return 122;
            5'd4:    return 118;
            5'd5:    return 113;
            5'd6:    return 106;
            5'd7:    return 99;
            5'd8:    return 91;
            5'd9:    return 81;
            5'd10:   return 71;
            5'd11:   return 60;
            5'd12:   return 49;
            5'd13:   return 37;
            5'd14:   return 25;
            5'd15:   return 13;
            default: return 0;
        endcase
    endfunction

    // Only +1.0 is unrepresentable in Q1.7; -1.0 fits exactly.
    function automatic int clamp_q17(input int v);
        return (v > W_MAX) ? W_MAX : v;
    endfunction

    assign m  = 6'(k_i) * 6'(64 / N_POINTS);
    assign r  = {1'b0, m[3:0]};
    assign rc = 5'd16 - r;

    always_comb begin
        c = 0;
        s = 0;
        case (m[5:4])
            2'd0: begin c =  qcos(r);  s =  qcos(rc); end
            2'd1: begin c = -qcos(rc); s =  qcos(r);  end
            2'd2: begin c = -qcos(r);  s = -qcos(rc); end
            default: begin c = qcos(rc); s = -qcos(r); end
        endcase
    end

    assign w_re_o = TW'(clamp_q17(c));
    assign w_im_o = TW'(clamp_q17(-s));
endmodule

// File: rtl/fft_twiddle_stage.sv
// Streaming twiddle multiply: tags each sample with index k, multiplies by W_N^k, saturates to DW bits.
module fft_twiddle_stage
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int LOG_N    = FFT_LOG_N,
    parameter int DW       = FFT_DW,
    parameter int TW       = FFT_TW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG_N-1:0] out_k,
    output logic             out_last,
    output logic             sat_flag
);
    localparam int PW = DW + TW;
    localparam int SW = PW - FRAC_SH;
    localparam logic signed [SW:0] SAT_HI = (SW + 1)'(SAT_MAX);
    localparam logic signed [SW:0] SAT_LO = (SW + 1)'(SAT_MIN);
    localparam logic [LOG_N-1:0]   K_LAST = LOG_N'(N_POINTS - 1);

    function automatic logic signed [DW-1:0] sat17(input logic signed [SW:0] s);
        if (s > SAT_HI) return DW'(SAT_HI);
        if (s < SAT_LO) return DW'(SAT_LO);
        return DW'(s);
    endfunction

    function automatic logic clamps(input logic signed [SW:0] s);
        return (s > SAT_HI) || (s < SAT_LO);
    endfunction

    logic                    en;
    logic                    accept;
    logic [LOG_N-1:0]        k_sel;
    logic [LOG_N-1:0]        cnt_q, cnt_d;
    logic signed [TW-1:0]    w_re, w_im;

    logic                    vld_p1_q;
    logic signed [DW-1:0]    re_p1_q, im_p1_q;
    logic signed [TW-1:0]    w_re_p1_q, w_im_p1_q;
    logic [LOG_N-1:0]        k_p1_q;

    logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0]    s_rr, s_ii, s_ri, s_ir;
    logic signed [SW:0]      sum_re, sum_im;

    logic                    vld_p2_q;
    logic signed [DW-1:0]    re_p2_q, im_p2_q;
    logic [LOG_N-1:0]        k_p2_q;
    logic                    last_p2_q;
    logic                    sat_q;

    assign en       = !vld_p2_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign k_sel    = in_sof ? '0 : cnt_q;
    assign cnt_d    = accept ? k_sel + LOG_N'(1) : cnt_q;

    twiddle_rom #(
        .N_POINTS (N_POINTS),
        .LOG_N    (LOG_N),
        .TW       (TW)
    ) u_rom (
        .k_i    (k_sel),
        .w_re_o (w_re),
        .w_im_o (w_im)
    );

    // Stage 1: capture sample, index and twiddle
    always_ff @(posedge clk) begin
        if (en) begin
            re_p1_q   <= in_re;
            im_p1_q   <= in_im;
            w_re_p1_q <= w_re;
            w_im_p1_q <= w_im;
            k_p1_q    <= k_sel;
        end
    end

    // Full-precision products; dropping the low FRAC_SH bits is a floor shift.
    assign p_rr = PW'(re_p1_q) * PW'(w_re_p1_q);
    assign p_ii = PW'(im_p1_q) * PW'(w_im_p1_q);
    assign p_ri = PW'(re_p1_q) * PW'(w_im_p1_q);
    assign p_ir = PW'(im_p1_q) * PW'(w_re_p1_q);
    assign s_rr = p_rr[PW-1:FRAC_SH];
    assign s_ii = p_ii[PW-1:FRAC_SH];
    assign s_ri = p_ri[PW-1:FRAC_SH];
    assign s_ir = p_ir[PW-1:FRAC_SH];
    assign sum_re = $signed({s_rr[SW-1], s_rr}) - $signed({s_ii[SW-1], s_ii});
    assign sum_im = $signed({s_ri[SW-1], s_ri}) + $signed({s_ir[SW-1], s_ir});

    // Stage 2: saturate and present; whole pipe and counter hold while en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            re_p2_q   <= '0;
            im_p2_q   <= '0;
            k_p2_q    <= '0;
            last_p2_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (en) begin
                vld_p1_q  <= accept;
                vld_p2_q  <= vld_p1_q;
                re_p2_q   <= sat17(sum_re);
                im_p2_q   <= sat17(sum_im);
                k_p2_q    <= k_p1_q;
                last_p2_q <= (k_p1_q == K_LAST);
                if (vld_p1_q && (clamps(sum_re) || clamps(sum_im))) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign out_re    = re_p2_q;
    assign out_im    = im_p2_q;
    assign out_k     = k_p2_q;
    assign out_last  = last_p2_q;
    assign sat_flag  = sat_q;
endmodule

// File: doc/fft_twiddle_stage.md
Name: fft_twiddle_stage

Overview:
Streaming twiddle-multiply stage of the radix-2 FFT datapath, placed directly after the butterfly adder stage. It accepts one complex sample per handshake and tags it with twiddle index k from an internal counter. It multiplies the sample by W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) using a Q1.7 twiddle ROM. Results go out through a 2-stage stallable pipeline with saturation to the 17-bit sample format.

Parameters:
N_POINTS, 16, twiddle period N; power of two, 2..64
LOG_N, 4, log2(N_POINTS); width of k
DW, 17, sample component width, two's complement
TW, 8, twiddle component width, Q1.7 two's complement

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  stage can accept input this cycle
in_sof  in  1  start of frame, qualified by in_valid && in_ready
in_re  in  DW  input real part
in_im  in  DW  input imaginary part
out_valid  out  1  output sample valid
out_ready  in  1  downstream can accept
out_re  out  DW  product real part, saturated
out_im  out  DW  product imaginary part, saturated
out_k  out  LOG_N  twiddle index applied to this output
out_last  out  1  output used k = N_POINTS-1
sat_flag  out  1  sticky: some output saturated since reset

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: in_ready=1. out_valid=0, out_re=0, out_im=0, out_k=0, out_last=0, sat_flag=0. Index counter k=0. Both pipeline valids=0.
- Reset mid-frame: in-flight data is discarded. The next accepted sample uses k=0.
- Global advance: en = !out_valid || out_ready. in_ready = en, combinational.
- Accept: accept = in_valid && in_ready.
- Index for an accepted sample: in_sof=1 -> uses k=0, counter becomes 1. Otherwise -> uses counter value, counter becomes (k+1) mod N_POINTS. The counter wraps from N-1 to 0 without needing sof.
- S1, registered when en: input sample, k, and ROM twiddle (w_re, w_im). S1 valid <= accept.
- Products in S1 (25-bit full precision):
  - p_rr = re*w_re
  - p_ii = im*w_im
  - p_ri = re*w_im
  - p_ir = im*w_re
  - each shifted arithmetic right by 7, floor (no rounding), giving 18-bit values.
- S2, registered when en:
  - out_re = sat17(p_rr - p_ii), out_im = sat17(p_ri + p_ir), both sums 19-bit.
  - sat17 clamps to [-65536, 65535].
  - out_k and out_last carried from S1. out_valid <= S1 valid.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays 1. Throughput is 1 sample per clock.
- Stall: out_valid && !out_ready freezes S1, S2, and the counter. out_* stay stable. No sample is dropped or duplicated.
- Simultaneous events: when out_ready rises while in_valid=1, the output handoff and the new accept happen in the same cycle.
- sat_flag: sets when an S2 load clamps either component. Cleared only by reset.
- Twiddle ROM contents:
  - w_re = round(128*cos(2*pi*k/N)), w_im = round(-128*sin(2*pi*k/N)).
  - +128 clamps to 127. -128 is kept.
  - N=16: k0=(127,0), k2=(91,-91), k4=(0,-128), k8=(-128,0), k12=(0,127).

Decomposition:
- Package fft_pkg:
  - DW, TW, and LOG_N constants.
  - sat17 limits: SAT_MAX=65535, SAT_MIN=-65536.
  - Q1.7 fraction shift constant, 7.
- Sub-module twiddle_rom: combinational index -> (w_re, w_im), table built for N_POINTS.
- Product, sum, and saturate logic stays inline in this block.

Test Plan:
1. Reset, then in=(256,0) with sof, out_ready=1 -> 2 cycles later out=(254,0), out_k=0, sat_flag=0.
2. Stream 16 samples of (256,0), sof on the first only -> out_k runs 0..15 with out_last on k=15; k=4 gives (0,-256); k=8 gives (-256,0). A 17th sample without sof gets k=0.
3. in=(-65536,-65536) at k=8 -> out=(65535,65535), sat_flag=1 and stays 1 afterwards.
4. Hold out_ready=0 with 3 samples offered -> 2 are accepted, then in_ready=0; outputs stay frozen. Releasing out_ready -> all 3 arrive in order, with no gaps or duplicates.
5. Pulse sof on the 5th sample mid-frame -> that sample uses k=0 and the next uses k=1.
6. Assert rst_n=0 asynchronously with 2 samples in flight -> out_valid drops immediately and nothing is emitted after release. The next sample uses k=0.
